barrel_shift_pipe: RTL
======================

// Module: barrel_shift_pipe
// PURPOSE
//  Parametrised, pipelined barrel shifter: generalises the fixed 4-bit mux-based shifter
//  to WIDTH bits and four shift modes. Built from log2(WIDTH) registered 2:1-mux levels.
//  Valid/ready handshake on both sides. Sits between operand fetch and result writeback.
// PARAMETERS
//  WIDTH   8   data width; power of two, >= 2
//  AMT_W   $clog2(WIDTH)   shift-amount width; derived, do not override
//  LEVELS  AMT_W   pipeline depth = number of shift levels; derived
// PORTS
//  clk        in   1      rising-edge clock
//  rst_n      in   1      asynchronous active-low reset
//  in_valid   in   1      input operand valid
//  in_ready   out  1      block can accept operand this cycle
//  in_data    in   WIDTH  operand
//  in_amt     in   AMT_W  shift amount, 0..WIDTH-1
//  in_mode    in   2      00 SLL, 01 SRL, 10 SRA, 11 ROR
//  out_valid  out  1      result valid
//  out_ready  in   1      downstream accepts result
//  out_data   out  WIDTH  shifted result
//  out_zero   out  1      result == 0 (only with BSH_ZERO_FLAG_EN)
// BEHAVIOUR
//  - Reset (rst_n=0, async): every stage valid, data, amt, mode register -> 0; out_valid=0,
//    out_data=0, out_zero=0. Reset mid-operation drops all in-flight operands; none emerge.
//  - Transfer: input accepted when in_valid & in_ready; output consumed when out_valid & out_ready.
//  - Global advance: adv = out_ready | ~out_valid. All stages load when adv=1, hold when 0.
//    in_ready = adv (combinational from out_ready and last-stage valid).
//  - Level k (k=0..LEVELS-1) shifts by 2^k when amt[k]=1, else passes; registered at its output.
//    Latency LEVELS cycles accept->out_valid; throughput 1 operand/cycle with out_ready=1.
//  - Bubbles: a stage with valid=0 still advances when adv=1 (bubbles collapse only via adv).
//  - SLL: zero fill from LSB. SRL: zero fill from MSB. SRA: fill with in_data[WIDTH-1]
//    (sign captured at entry, carried with data). ROR: bits leaving LSB re-enter at MSB.
//  - amt=0 in any mode: out_data = in_data. amt and mode travel with the operand; later
//    operands never affect earlier ones.
//  - Holding out_valid=1 with out_ready=0: out_data, out_zero stable until consumed.
//  - in_valid=0 while adv=1: bubble enters; in_data ignored.
// CONFIGURATION
//  BSH_ZERO_FLAG_EN defined: out_zero port present; registered with out_data, set when the
//    result at the last stage is all zeros; reset 0; cleared with out_valid semantics (valid
//    only when out_valid=1).
//  BSH_ZERO_FLAG_EN undefined: out_zero port and its logic absent; all else identical.
// STRUCTURE
//  - Package barrel_shift_pkg: typedef enum logic [1:0] bsh_mode_t {BSH_SLL, BSH_SRL,
//    BSH_SRA, BSH_ROR}; localparam helpers for AMT_W.
//  - Sub-module barrel_shift_stage #(WIDTH, SHIFT): one mux level + pipeline register
//    (data, amt, mode, sign, valid) with enable = adv; generate-instantiated LEVELS times.
// TESTING (WIDTH=8, out_ready=1 unless noted)
//  1 din=8'h96, amt=3: SLL->8'hB0, SRL->8'h12, SRA->8'hF2, ROR->8'hD2, each 3 cycles later.
//  2 amt=0 on 8'hA5 in all four modes -> 8'hA5; amt=7 SRA on 8'h80 -> 8'hFF; SLL 8'h01 -> 8'h80.
//  3 Back-to-back 16 random operands every cycle -> 16 results in order, one per cycle,
//    matching golden model; in_ready stays 1.
//  4 Backpressure: out_ready=0 for 5 cycles with pipe full -> in_ready=0, out_data held,
//    no operand lost or duplicated after out_ready returns to 1.
//  5 Reset mid-flight: assert rst_n=0 with 3 operands in pipe -> out_valid=0 immediately,
//    no stale result after release; next operand emerges after 3 cycles.
//  6 BSH_ZERO_FLAG_EN: SRL 8'h04 by 3 -> out_data=0, out_zero=1; SRL by 2 -> out_zero=0.

Source files
------------

// File: rtl/barrel_shift_pkg.sv
// Shared types and width helpers for the pipelined barrel shifter.
package barrel_shift_pkg;

  typedef enum logic [1:0] {
    BSH_SLL = 2'b00,
    BSH_SRL = 2'b01,
    BSH_SRA = 2'b10,
    BSH_ROR = 2'b11
  } bsh_mode_t;

  // Shift-amount width for a given data width; never narrower than one bit.
  function automatic int bsh_amt_width(input int width);
    return (width < 2) ? 1 : $clog2(width);
  endfunction

endpackage

// File: rtl/barrel_shift_stage.sv
// One level of the barrel shifter: a fixed shift by SHIFT bits applied when the
// matching amount bit is set, followed by the pipeline register that carries the
// operand's data, amount, mode, sign and valid to the next level.
module barrel_shift_stage
  import barrel_shift_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int SHIFT = 1,
  localparam int AMT_W = bsh_amt_width(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  input  logic [AMT_W-1:0] in_amt,
  input  bsh_mode_t        in_mode,
  input  logic             in_sign,
  output logic [WIDTH-1:0] nxt_data,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  output logic [AMT_W-1:0] out_amt,
  output bsh_mode_t        out_mode,
  output logic             out_sign
);

  // Amount bit that selects this level.
  localparam int LVL = $clog2(SHIFT);

  logic [WIDTH-1:0] shifted;

  // Fixed-distance shift for the operand's mode, then the 2:1 level mux.
  always_comb begin
    shifted = in_data;
    case (in_mode)
      BSH_SLL: shifted = in_data << SHIFT;
      BSH_SRL: shifted = in_data >> SHIFT;
      BSH_SRA: shifted = (in_data >> SHIFT) |
                         (in_sign ? ~({WIDTH{1'b1}} >> SHIFT) : {WIDTH{1'b0}});
      BSH_ROR: shifted = (in_data >> SHIFT) | (in_data << (WIDTH - SHIFT));
      default: shifted = in_data;
    endcase
    nxt_data = in_amt[LVL] ? shifted : in_data;
  end

  // Pipeline register; the whole pipe moves together on en, bubbles included.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_amt   <= '0;
      out_mode  <= BSH_SLL;
      out_sign  <= 1'b0;
    end else if (en) begin
      out_valid <= in_valid;
      out_data  <= nxt_data;
      out_amt   <= in_amt;
      out_mode  <= in_mode;
      out_sign  <= in_sign;
    end
  end

endmodule

// File: rtl/barrel_shift_pipe.sv
// Pipelined WIDTH-bit barrel shifter (SLL/SRL/SRA/ROR) with valid/ready on both
// sides. One registered mux level per amount bit, so latency is log2(WIDTH).
// Optional feature: define BSH_ZERO_FLAG_EN to add the registered out_zero flag.
module barrel_shift_pipe
  import barrel_shift_pkg::*;
#(
  parameter int WIDTH = 8,
  localparam int AMT_W = bsh_amt_width(WIDTH),
  localparam int LEVELS = AMT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [AMT_W-1:0] in_amt,
  input  logic [1:0]       in_mode,
  output logic             out_valid,
  input  logic             out_ready,
`ifdef BSH_ZERO_FLAG_EN
  output logic             out_zero,
`endif
  output logic [WIDTH-1:0] out_data
);

  // Index 0 is the input port; index k+1 is the register of level k.
  logic             v_s    [LEVELS+1];
  logic [WIDTH-1:0] d_s    [LEVELS+1];
  logic [AMT_W-1:0] amt_s  [LEVELS+1];
  bsh_mode_t        mode_s [LEVELS+1];
  logic             sign_s [LEVELS+1];
  logic [WIDTH-1:0] nxt_s  [LEVELS];

  logic adv;

  // Single global stall: everything advances unless a result is waiting unconsumed.
  assign adv      = out_ready | ~out_valid;
  assign in_ready = adv;

  assign v_s[0]    = in_valid;
  assign d_s[0]    = in_data;
  assign amt_s[0]  = in_amt;
  assign mode_s[0] = bsh_mode_t'(in_mode);
  // Sign is captured once at entry so SRA fill never depends on partially shifted data.
  assign sign_s[0] = in_data[WIDTH-1];

  for (genvar k = 0; k < LEVELS; k++) begin : g_level
    barrel_shift_stage #(
      .WIDTH (WIDTH),
      .SHIFT (1 << k)
    ) u_stage (
      .clk       (clk),
      .rst_n     (rst_n),
      .en        (adv),
      .in_valid  (v_s[k]),
      .in_data   (d_s[k]),
      .in_amt    (amt_s[k]),
      .in_mode   (mode_s[k]),
      .in_sign   (sign_s[k]),
      .nxt_data  (nxt_s[k]),
      .out_valid (v_s[k+1]),
      .out_data  (d_s[k+1]),
      .out_amt   (amt_s[k+1]),
      .out_mode  (mode_s[k+1]),
      .out_sign  (sign_s[k+1])
    );
  end

  assign out_valid = v_s[LEVELS];
  assign out_data  = d_s[LEVELS];

`ifdef BSH_ZERO_FLAG_EN
  logic zero_q;

  // Zero flag is registered alongside the last level so it lines up with out_data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      zero_q <= 1'b0;
    end else if (adv) begin
      zero_q <= v_s[LEVELS-1] && (nxt_s[LEVELS-1] == '0);
    end
  end

  assign out_zero = zero_q;
`endif

  // Tail side-band fields and per-level mux outputs only feed the last level or the
  // optional flag; collect them so they are visibly consumed in every build.
  logic [LEVELS-1:0] unused_nxt;
  logic              unused_tail;

  for (genvar k = 0; k < LEVELS; k++) begin : g_sink
    assign unused_nxt[k] = ^nxt_s[k];
  end

  assign unused_tail = ^{amt_s[LEVELS], mode_s[LEVELS], sign_s[LEVELS], unused_nxt};

endmodule
